// File: rtl/multicycle_sequencer_pkg.sv
// ============================================================================
// multicycle_sequencer_pkg
// Shared state encoding, opcode and ALU-class constants for the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [2:0] ALUOP_ADD  = 3'b000;
    localparam logic [2:0] ALUOP_SUB  = 3'b001;
    localparam logic [2:0] ALUOP_FUNC = 3'b010;

    function automatic logic [2:0] alu_class(input logic [5:0] op);
        case (op)
            OP_RTYPE: alu_class = ALUOP_FUNC;
            OP_BEQ:   alu_class = ALUOP_SUB;
            default:  alu_class = ALUOP_ADD;
        endcase
    endfunction

    function automatic logic op_known(input logic [5:0] op);
        op_known = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                   (op == OP_BEQ)   || (op == OP_HALT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_sequencer_pc_unit.sv
// ============================================================================
// multicycle_sequencer_pc_unit
// Program counter: sequential advance or branch target, updated on en_i.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_sequencer_pc_unit
    import multicycle_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        taken_i,
    input  logic [15:0] imm_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] w_offset;

    // Word-aligned, sign-extended branch displacement.
    assign w_offset = taken_i ? {{14{imm_i[15]}}, imm_i, 2'b00} : 32'd0;

    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            pc_d = pc_q + 32'(PC_STEP) + w_offset;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// multicycle_sequencer
// Multi-cycle R-type/lw/sw/beq controller with registered Moore outputs.
// Optional: define MEM_WAIT_EN to stretch MEMORY by MEM_WAIT_CYCLES cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned PC_STEP         = 4,
    parameter int unsigned MEM_WAIT_CYCLES = 2,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr_data,
    output logic             instr_ready,
    output logic [31:0]      instr_q,
    input  logic             zf_in,
    output logic             reg_write,
    output logic             mem_to_write,
    output logic             mem_to_reg,
    output logic [2:0]       alu_op,
    output logic [31:0]      pc_out,
    output logic             done,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(MEM_WAIT_CYCLES + 2);
`ifdef MEM_WAIT_EN
    localparam int unsigned WAIT_CYC = MEM_WAIT_CYCLES;
`else
    localparam int unsigned WAIT_CYC = 0;
`endif

    state_t             state_q, state_d;
    logic [31:0]        instr_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [5:0]         w_opc;
    logic               ready_q, reg_write_q, mem_to_write_q, mem_to_reg_q;
    logic               done_q, illegal_q, halted_q;
    logic [2:0]         alu_op_q;
    logic [CNT_W-1:0]   count_q;
    logic               ready_d, reg_write_d, mem_to_write_d, mem_to_reg_d;
    logic               done_d, illegal_d, halted_d;
    logic [2:0]         alu_op_d;
    logic               w_mem_last_d;

    assign w_opc = instr_d[31:26];

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        // wait_d always tracks the counter value of the cycle state_d names.
        wait_d  = (state_q == S_MEMORY && wait_q != '0) ? wait_q - WAIT_W'(1)
                                                         : WAIT_W'(WAIT_CYC);
        case (state_q)
            S_IDLE: begin
                if (instr_valid && ready_q) begin
                    instr_d = instr_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_opc)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ: state_d = S_EXECUTE;
                    OP_HALT:                        state_d = S_HALT;
                    default:                        state_d = S_IDLE;
                endcase
            end
            S_EXECUTE: begin
                case (w_opc)
                    OP_RTYPE:     state_d = S_WRITEBACK;
                    OP_LW, OP_SW: state_d = S_MEMORY;
                    default:      state_d = S_IDLE;
                endcase
            end
            S_MEMORY: begin
                if (wait_q == '0) begin
                    state_d = (w_opc == OP_LW) ? S_WRITEBACK : S_IDLE;
                end
            end
            S_WRITEBACK: state_d = S_IDLE;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_mem_last_d   = (state_d == S_MEMORY) && (wait_d == '0);
        ready_d        = (state_d == S_IDLE);
        halted_d       = (state_d == S_HALT);
        illegal_d      = (state_d == S_DECODE) && !op_known(w_opc);
        alu_op_d       = '0;
        if (state_d == S_EXECUTE || state_d == S_MEMORY || state_d == S_WRITEBACK) begin
            alu_op_d = alu_class(w_opc);
        end
        mem_to_write_d = w_mem_last_d && (w_opc == OP_SW);
        reg_write_d    = (state_d == S_WRITEBACK);
        mem_to_reg_d   = (state_d == S_WRITEBACK) && (w_opc == OP_LW);
        done_d         = (state_d == S_WRITEBACK) || mem_to_write_d ||
                         ((state_d == S_EXECUTE) && (w_opc == OP_BEQ));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            instr_q        <= '0;
            wait_q         <= '0;
            ready_q        <= 1'b0;
            reg_write_q    <= 1'b0;
            mem_to_write_q <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            done_q         <= 1'b0;
            illegal_q      <= 1'b0;
            halted_q       <= 1'b0;
            alu_op_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            wait_q         <= wait_d;
            ready_q        <= ready_d;
            reg_write_q    <= reg_write_d;
            mem_to_write_q <= mem_to_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
            done_q         <= done_d;
            illegal_q      <= illegal_d;
            halted_q       <= halted_d;
            alu_op_q       <= alu_op_d;
            if (done_q && count_q != '1) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // PC and count advance on the edge that closes the retiring cycle, so a
    // beq sees zf_in while the ALU is still evaluating its compare.
    multicycle_sequencer_pc_unit #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_unit (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (done_q || illegal_q),
        .taken_i (done_q && (instr_q[31:26] == OP_BEQ) && zf_in),
        .imm_i   (instr_q[15:0]),
        .pc_o    (pc_out)
    );

    assign instr_ready  = ready_q;
    assign reg_write    = reg_write_q;
    assign mem_to_write = mem_to_write_q;
    assign mem_to_reg   = mem_to_reg_q;
    assign alu_op       = alu_op_q;
    assign done         = done_q;
    assign illegal      = illegal_q;
    assign halted       = halted_q;
    assign instr_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// tb_multicycle_sequencer
// Directed plus random instruction stream against an opcode-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_sequencer;

`ifdef MEM_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif
    localparam logic [5:0] T_R = 6'h00, T_LW = 6'h23, T_SW = 6'h2B;
    localparam logic [5:0] T_BEQ = 6'h04, T_HALT = 6'h3F;

    logic        clk, rst_n, instr_valid, zf_in;
    logic [31:0] instr_data, instr_q, pc_out;
    logic        instr_ready, reg_write, mem_to_write, mem_to_reg;
    logic        done, illegal, halted;
    logic [2:0]  alu_op;
    logic [15:0] instr_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mpc;
    int          mcnt;

    multicycle_sequencer #(
        .RESET_PC        (32'h0000_0000),
        .PC_STEP         (4),
        .MEM_WAIT_CYCLES (2),
        .CNT_W           (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_ready  (instr_ready),
        .instr_q      (instr_q),
        .zf_in        (zf_in),
        .reg_write    (reg_write),
        .mem_to_write (mem_to_write),
        .mem_to_reg   (mem_to_reg),
        .alu_op       (alu_op),
        .pc_out       (pc_out),
        .done         (done),
        .illegal      (illegal),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {done, illegal, reg_write, mem_to_write, mem_to_reg, alu_op, ready, halted}
    function automatic logic [31:0] ctl_vec();
        return {22'd0, done, illegal, reg_write, mem_to_write, mem_to_reg,
                alu_op, instr_ready, halted};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ctl"}, ctl_vec(), 32'd0);
        chk({tag, "_pc"}, pc_out, 32'd0);
        chk({tag, "_iq"}, instr_q, 32'd0);
        chk({tag, "_cnt"}, {16'd0, instr_count}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        #1 check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_low_at_release", {31'd0, instr_ready}, 32'd0);
        mpc  = 32'd0;
        mcnt = 0;
    endtask

    // Issue one non-halt instruction and check every cycle through retirement.
    task automatic run_instr(input logic [31:0] ins, input logic zf);
        logic [5:0]  op;
        logic        legal, uses_wb;
        logic [2:0]  cls;
        logic [31:0] exp;
        int          lat;
        shortint     imm;
        op  = ins[31:26];
        imm = ins[15:0];
        legal = 1'b1;
        uses_wb = (op == T_R) || (op == T_LW);
        cls = 3'b000;
        case (op)
            T_R:     begin lat = 3;     cls = 3'b010; end
            T_LW:    lat = 4 + W;
            T_SW:    lat = 3 + W;
            T_BEQ:   begin lat = 2;     cls = 3'b001; end
            default: begin lat = 1;     legal = 1'b0; end
        endcase
        wait_ready();
        instr_data  = ins;
        instr_valid = 1'b1;
        zf_in       = zf;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            instr_valid = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            instr_data  = $urandom;
            @(negedge clk);
            exp = {22'd0,
                   legal && k == lat,
                   !legal && k == 1,
                   uses_wb && k == lat,
                   op == T_SW && k == lat,
                   op == T_LW && k == lat,
                   (legal && k >= 2) ? cls : 3'b000,
                   1'b0, 1'b0};
            chk($sformatf("ctl_op%02h_k%0d", op, k), ctl_vec(), exp);
            chk($sformatf("iq_k%0d", k), instr_q, ins);
        end
        if (op == T_BEQ && zf) mpc = mpc + 32'(4 + 4 * int'(imm));
        else                   mpc = mpc + 32'd4;
        if (legal && mcnt != 65535) mcnt++;
        @(negedge clk);
        chk("pc_after", pc_out, mpc);
        chk("cnt_after", {16'd0, instr_count}, 32'(mcnt));
        chk("idle_ctl", ctl_vec(), 32'h0000_0002);
    endtask

    initial begin
        logic [31:0] ins;
        logic [5:0]  op;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = 32'd0;
        zf_in       = 1'b0;
        #12;
        check_reset_state("por");
        do_reset();

        run_instr(32'h012A_4020, 1'b0);
        run_instr(32'h8D09_0004, 1'b0);
        run_instr(32'h1000_0003, 1'b1);
        chk("beq_taken_pc", pc_out, 32'd24);

        do_reset();
        run_instr(32'h012A_4020, 1'b1);
        run_instr(32'hAD09_0008, 1'b1);
        run_instr(32'h1000_0003, 1'b0);
        chk("beq_not_taken_pc", pc_out, 32'd12);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: op = T_R;
                1: op = T_LW;
                2: op = T_SW;
                3: op = T_BEQ;
                default: begin
                    op = 6'($urandom);
                    while (op == T_R || op == T_LW || op == T_SW ||
                           op == T_BEQ || op == T_HALT) op = 6'($urandom);
                end
            endcase
            ins = {op, 26'($urandom)};
            run_instr(ins, 1'($urandom_range(0, 1)));
        end

        // Reset while a lw sits in MEMORY.
        wait_ready();
        instr_data  = 32'h8D09_0004;
        instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lw_in_memory_alu", {29'd0, alu_op}, 32'd0);
        rst_n = 1'b0;
        #1 check_reset_state("mid_lw_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_low_after_release", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("ready_first_cycle", {31'd0, instr_ready}, 32'd1);
        mpc  = 32'd0;
        mcnt = 0;

        run_instr(32'hE800_0000, 1'b0);
        chk("illegal_pc", pc_out, 32'd4);

        wait_ready();
        instr_data  = {T_HALT, 26'd0};
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("halt_decode_ctl", ctl_vec(), 32'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("halt_ctl_c%0d", c), ctl_vec(), 32'h0000_0001);
            chk($sformatf("halt_pc_c%0d", c), pc_out, mpc);
        end
        chk("halt_cnt", {16'd0, instr_count}, 32'(mcnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
